// File: rtl/key_event_decoder.sv
// Debounced active-low key level to single-cycle press/release/click/long/repeat events.
// Define KEY_REPEAT_EN to enable auto-repeat pulses while the key stays in HELD.
module key_event_decoder #(
   parameter int CLK_PER_MS = 50_000,
   parameter int LONG_MS    = 1000,
   parameter int REPEAT_MS  = 200
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_deb,
   output logic key_press,
   output logic key_release,
   output logic key_click,
   output logic key_long,
   output logic key_repeat,
   output logic key_held
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PRESSED = 2'd1;
   localparam logic [1:0] S_HELD    = 2'd2;

   localparam logic [16:0] PRESC_MAX = 17'(CLK_PER_MS - 1);
   localparam logic [15:0] LONG_M1   = 16'(LONG_MS - 1);
`ifdef KEY_REPEAT_EN
   localparam logic [15:0] REP_M1    = 16'(REPEAT_MS - 1);
`endif

   logic [1:0]  state;
   logic        key_prev;
   logic [16:0] presc;
   logic [15:0] ms_cnt;
   logic        fall, rise, tick;

   assign fall = key_prev & ~key_deb;
   assign rise = ~key_prev & key_deb;
   assign tick = (presc == PRESC_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         key_prev    <= 1'b1;
         presc       <= '0;
         ms_cnt      <= '0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_click   <= 1'b0;
         key_long    <= 1'b0;
         key_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
         key_repeat  <= 1'b0;
`endif
      end else begin
         key_prev    <= key_deb;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_click   <= 1'b0;
         key_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
         key_repeat  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               presc  <= '0;
               ms_cnt <= '0;
               if (fall) begin
                  state     <= S_PRESSED;
                  key_press <= 1'b1;
               end
            end
            S_PRESSED: begin
               // Release takes priority over a threshold tick on the same edge
               if (rise) begin
                  state       <= S_IDLE;
                  key_release <= 1'b1;
                  key_click   <= 1'b1;
                  presc       <= '0;
                  ms_cnt      <= '0;
               end else begin
                  presc <= tick ? 17'd0 : presc + 17'd1;
                  if (tick) begin
                     if (ms_cnt == LONG_M1) begin
                        state    <= S_HELD;
                        key_long <= 1'b1;
                        key_held <= 1'b1;
                        ms_cnt   <= '0;
                     end else begin
                        ms_cnt <= ms_cnt + 16'd1;
                     end
                  end
               end
            end
            S_HELD: begin
               if (rise) begin
                  state       <= S_IDLE;
                  key_release <= 1'b1;
                  key_held    <= 1'b0;
                  presc       <= '0;
                  ms_cnt      <= '0;
               end else begin
`ifdef KEY_REPEAT_EN
                  // Prescaler phase carries over from PRESSED so repeats stay on the ms grid
                  presc <= tick ? 17'd0 : presc + 17'd1;
                  if (tick) begin
                     if (ms_cnt == REP_M1) begin
                        key_repeat <= 1'b1;
                        ms_cnt     <= '0;
                     end else begin
                        ms_cnt <= ms_cnt + 16'd1;
                     end
                  end
`else
                  presc  <= '0;
                  ms_cnt <= '0;
`endif
               end
            end
            default: begin
               state    <= S_IDLE;
               key_held <= 1'b0;
               presc    <= '0;
               ms_cnt   <= '0;
            end
         endcase
      end
   end

`ifndef KEY_REPEAT_EN
   assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: CLK_PER_MS=10, LONG_MS=5, REPEAT_MS=2.
// Repeat expectations follow whether KEY_REPEAT_EN is defined for the build.
module tb_key_event_decoder;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic key_deb = 1'b1;
   logic key_press, key_release, key_click, key_long, key_repeat, key_held;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int n_press, n_rel, n_click, n_long, n_rep, n_held;
   int e_press, e_rel, e_click, e_long, f_rep, e_rep, f_held;

   key_event_decoder #(.CLK_PER_MS(10), .LONG_MS(5), .REPEAT_MS(2)) dut (
      .clk(clk), .rstn(rstn), .key_deb(key_deb),
      .key_press(key_press), .key_release(key_release), .key_click(key_click),
      .key_long(key_long), .key_repeat(key_repeat), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // edge numbering: edge 1 is the first posedge after reset release
   always @(posedge clk or negedge rstn)
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (key_press)   begin n_press++; e_press = cyc; end
      if (key_release) begin n_rel++;   e_rel   = cyc; end
      if (key_click)   begin n_click++; e_click = cyc; end
      if (key_long)    begin n_long++;  e_long  = cyc; end
      if (key_repeat)  begin if (n_rep == 0) f_rep = cyc; n_rep++; e_rep = cyc; end
      if (key_held)    begin if (n_held == 0) f_held = cyc; n_held++; end
   end

   task automatic clear_log();
      n_press = 0; n_rel = 0; n_click = 0; n_long = 0; n_rep = 0; n_held = 0;
      e_press = -1; e_rel = -1; e_click = -1; e_long = -1; f_rep = -1; e_rep = -1; f_held = -1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_edge(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(posedge clk); #2;
         guard++;
      end
      if (guard >= 2000) begin
         checks++; errors++;
         $display("FAIL wait_edge: reached edge %0d, wanted %0d", cyc, n);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      key_deb = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      clear_log();
   endtask

   function automatic int outs();
      return {26'd0, key_press, key_release, key_click, key_long, key_repeat, key_held};
   endfunction

   initial begin
      clear_log();
      // reset state
      repeat (2) @(posedge clk);
      #2;
      chk("reset_outputs", outs(), 0);
      @(negedge clk);
      rstn = 1'b1;
      clear_log();
      wait_edge(20);
      chk("idle_no_events", n_press + n_rel + n_held, 0);

      // short press: fall at 100, rise at 130
      do_reset();
      wait_edge(99);  key_deb = 1'b0;
      wait_edge(129); key_deb = 1'b1;
      wait_edge(140);
      chk("short_press_cnt", n_press, 1);
      chk("short_press_edge", e_press, 100);
      chk("short_rel_edge", e_rel, 130);
      chk("short_click_edge", e_click, 130);
      chk("short_click_cnt", n_click, 1);
      chk("short_no_long", n_long, 0);
      chk("short_no_held", n_held, 0);

      // long hold: fall at 100, rise at 195
      do_reset();
      wait_edge(99);  key_deb = 1'b0;
      wait_edge(194); key_deb = 1'b1;
      wait_edge(210);
      chk("long_cnt", n_long, 1);
      chk("long_edge", e_long, 150);
      chk("long_held_rise", f_held, 150);
      chk("long_held_cycles", n_held, 45);
      chk("long_rel_edge", e_rel, 195);
      chk("long_no_click", n_click, 0);
`ifdef KEY_REPEAT_EN
      chk("long_rep_cnt", n_rep, 2);
      chk("long_rep_first", f_rep, 170);
      chk("long_rep_last", e_rep, 190);
`else
      chk("long_rep_cnt", n_rep, 0);
`endif

      // long hold for 200 cycles: fall at 100, rise at 300
      do_reset();
      wait_edge(99);  key_deb = 1'b0;
      wait_edge(299); key_deb = 1'b1;
      wait_edge(310);
      chk("hold200_long_edge", e_long, 150);
      chk("hold200_held_cycles", n_held, 150);
      chk("hold200_rel_edge", e_rel, 300);
`ifdef KEY_REPEAT_EN
      chk("hold200_rep_cnt", n_rep, 7);
      chk("hold200_rep_last", e_rep, 290);
`else
      chk("hold200_rep_cnt", n_rep, 0);
`endif

      // threshold collision: rise sampled at 150
      do_reset();
      wait_edge(99);  key_deb = 1'b0;
      wait_edge(149); key_deb = 1'b1;
      wait_edge(220);
      chk("coll_rel_edge", e_rel, 150);
      chk("coll_click_edge", e_click, 150);
      chk("coll_no_long", n_long, 0);
      chk("coll_no_held", n_held, 0);

      // reset mid-hold at edge 160 + 3 ns
      do_reset();
      wait_edge(99);  key_deb = 1'b0;
      wait_edge(160);
      chk("midhold_held_before", int'(key_held), 1);
      #1;
      rstn = 1'b0;
      #1;
      chk("midhold_outputs_zero", outs(), 0);
      clear_log();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      wait_edge(3);
      chk("midhold_no_release", n_rel, 0);
      chk("midhold_press_cnt", n_press, 1);
      chk("midhold_press_edge", e_press, 1);

      // minimum press: low for one sample at 100
      do_reset();
      wait_edge(99);  key_deb = 1'b0;
      wait_edge(100); key_deb = 1'b1;
      wait_edge(110);
      chk("min_press_edge", e_press, 100);
      chk("min_rel_edge", e_rel, 101);
      chk("min_click_edge", e_click, 101);
      chk("min_press_cnt", n_press, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
